// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer and the ALU
// it borrows: ALU opcodes, sequencer state encoding and operation select.
package alu_muldiv_seq_pkg;

    // ALU control opcodes (same encoding the EX-stage ALU control emits)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Operation select sampled with start
    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    // True while an iteration is in progress (the pipeline must stall)
    function automatic logic state_is_busy(input logic [1:0] st);
        return (st == ST_MUL) || (st == ST_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Single-cycle ALU shared with the EX stage. Purely combinational.
module alu_muldiv_seq_alu
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Opcode decode; unknown opcodes produce zero so nothing floats
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = in1 & in2;
            ALU_OR:  result = in1 | in2;
            ALU_ADD: result = in1 + in2;
            ALU_SUB: result = in1 - in2;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_NOR: result = ~(in1 | in2);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32-bit unsigned multiply (shift-add) and divide (restoring
// shift-subtract) built around the single-cycle ALU. One ALU operation per
// cycle, 32 iterations. {hi,lo} doubles as the working register pair:
// multiply keeps the partial product in hi and the multiplier in lo,
// divide keeps the remainder in hi and the dividend/quotient in lo.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [1:0]        state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;   // multiplicand M or divisor D
    logic              dbz_q, dbz_d;

    logic [3:0]        alu_op;
    logic [WIDTH-1:0]  alu_in1;
    logic [WIDTH-1:0]  alu_out;

    logic [WIDTH-1:0]  rs;         // low 32 bits of the shifted remainder
    logic              ovf;        // bit 32 of the shifted remainder
    logic              carry;      // carry out of hi + M
    logic              sub_ok;     // shifted remainder >= D
    logic              last_iter;

    // Divide step: remainder shifted left, pulling in the next dividend bit
    assign rs  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign ovf = hi_q[WIDTH-1];

    // ALU operand/opcode selection; add is the harmless default when idle
    always_comb begin
        alu_op  = ALU_ADD;
        alu_in1 = hi_q;
        if (state_q == ST_DIV) begin
            alu_op  = ALU_SUB;
            alu_in1 = rs;
        end
    end

    alu_muldiv_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .alu_op (alu_op),
        .in1    (alu_in1),
        .in2    (opnd_q),
        .result (alu_out),
        .zero   ()
    );

    // An unsigned sum that wrapped is smaller than either addend
    assign carry     = (alu_out < hi_q);
    // A 33-bit remainder with its top bit set always exceeds a 32-bit divisor
    assign sub_ok    = ovf || (rs >= opnd_q);
    assign last_iter = (cnt_q == ITER_W'(WIDTH - 1));

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (op == MD_OP_MUL) begin
                        hi_d    = '0;
                        lo_d    = b;
                        opnd_d  = a;
                        state_d = ST_MUL;
                    end else if (b == '0) begin
                        // No iterations: report max quotient, dividend as remainder
                        hi_d    = a;
                        lo_d    = '1;
                        opnd_d  = b;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = a;
                        opnd_d  = b;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + ITER_W'(1);
                if (lo_q[0]) begin
                    hi_d = {carry, alu_out[WIDTH-1:1]};
                    lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[WIDTH-1:1]};
                    lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                end
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + ITER_W'(1);
                lo_d  = {lo_q[WIDTH-2:0], sub_ok};
                hi_d  = sub_ok ? alu_out : rs;
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start here is deliberately dropped; the pipeline is still
                // capturing the result
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_is_busy(state_q);
    assign done        = (state_q == ST_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed scenarios plus random
// operations compared against plain 64-bit multiply and integer divide.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: the result the pipeline should capture, from plain arithmetic
    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] r;
        if (o == 1'b0) begin
            r = {32'd0, av} * {32'd0, bv};
        end else if (bv == 32'd0) begin
            r = {av, 32'hFFFFFFFF};
        end else begin
            r = {av % bv, av / bv};
        end
        return r;
    endfunction

    // Issue one request in cycle 0 and follow it until done (bounded).
    // lat = cycle in which done was seen (-1 if never), nbusy = busy cycles.
    // If inj_cyc > 0, a divide request 9/3 is pulsed in that cycle.
    task automatic do_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input int inj_cyc, output int lat, output int nbusy);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; lat = -1; nbusy = 0;
        while (cyc <= 100) begin
            if (done) begin
                lat = cyc;
                break;
            end
            if (busy) nbusy++;
            if (cyc == inj_cyc) begin
                start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d busy_cycles=%0d",
                 o, av, bv, hi, lo, div_by_zero, lat, nbusy);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_mul_small();
        int lat, nbusy;
        do_op(1'b0, 32'd7, 32'd6, 0, lat, nbusy);
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_small_latency: got %0d expected 33", lat); end
        checks++; if (nbusy != 32) begin errors++; $display("FAIL mul_small_busy: got %0d expected 32", nbusy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mul_small_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL mul_small_lo: got %h expected 2a", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_small_busy_at_done: got %b expected 0", busy); end
    endtask

    task automatic test_mul_carry();
        int lat, nbusy;
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, nbusy);
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_carry_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mul_carry_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_div();
        int lat, nbusy;
        do_op(1'b1, 32'd100, 32'd7, 0, lat, nbusy);
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_quot: got %h expected e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_rem: got %h expected 2", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz: got %b expected 0", div_by_zero); end
        do_op(1'b1, 32'hFFFFFFFF, 32'h80000001, 0, lat, nbusy);
        checks++; if (lo !== 32'd1) begin errors++; $display("FAIL div_ovf_quot: got %h expected 1", lo); end
        checks++; if (hi !== 32'h7FFFFFFE) begin errors++; $display("FAIL div_ovf_rem: got %h expected 7ffffffe", hi); end
    endtask

    task automatic test_div_zero();
        int lat, nbusy;
        do_op(1'b1, 32'd5, 32'd0, 0, lat, nbusy);
        checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL dbz_busy: got %0d expected 0", nbusy); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dbz_hi: got %h expected 5", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
        // Flag must survive a few idle cycles
        repeat (3) @(negedge clk);
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold: got %b expected 1", div_by_zero); end
        do_op(1'b0, 32'd3, 32'd3, 0, lat, nbusy);
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_cleared: got %b expected 0", div_by_zero); end
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL dbz_then_mul_lo: got %h expected 9", lo); end
    endtask

    task automatic test_busy_protect();
        int lat, nbusy, extra_done;
        do_op(1'b0, 32'd7, 32'd6, 10, lat, nbusy);
        checks++; if (lat != 33) begin errors++; $display("FAIL busy_prot_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL busy_prot_lo: got %h expected 2a", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_prot_hi: got %h expected 0", hi); end
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checks++; if (extra_done != 0) begin errors++; $display("FAIL busy_prot_extra_activity: got %0d expected 0", extra_done); end
    endtask

    task automatic test_done_hold();
        int lat, nbusy;
        do_op(1'b1, 32'd1000, 32'd33, 0, lat, nbusy);
        // We are in the done cycle: a start here must be dropped
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
        checks++; if (lo !== 32'd30) begin errors++; $display("FAIL hold_quot: got %h expected 1e", lo); end
        checks++; if (hi !== 32'd10) begin errors++; $display("FAIL hold_rem: got %h expected a", hi); end
    endtask

    task automatic test_reset_midop();
        int lat, nbusy, seen_done;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd123457; b = 32'd98765;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);   // now in cycle 15
        rst = 1'b1;
        @(negedge clk);               // cycle 16
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrst_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midrst_lo: got %h expected 0", lo); end
        seen_done = 0;
        repeat (30) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", seen_done); end
        $display("reset mid-operation applied");
        do_op(1'b1, 32'd12, 32'd4, 0, lat, nbusy);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL midrst_then_div_quot: got %h expected 3", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrst_then_div_rem: got %h expected 0", hi); end
    endtask

    task automatic test_random();
        int lat, nbusy, exp_lat;
        logic        o;
        logic [31:0] av, bv;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            o  = 1'($urandom_range(0, 1));
            av = $urandom;
            case ($urandom_range(0, 5))
                0: bv = 32'd0;
                1: bv = $urandom_range(1, 15);
                2: bv = av;
                default: bv = $urandom;
            endcase
            if (($urandom_range(0, 3)) == 0) av = av >> $urandom_range(0, 31);
            exp = ref_result(o, av, bv);
            exp_lat = (o == 1'b1 && bv == 32'd0) ? 1 : 33;
            do_op(o, av, bv, 0, lat, nbusy);
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
            checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h got %h_%h expected %h", i, o, av, bv, hi, lo, exp); end
            checks++; if (div_by_zero !== (o && bv == 32'd0)) begin errors++; $display("FAIL rand%0d_dbz: got %b expected %b", i, div_by_zero, (o && bv == 32'd0)); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        test_reset();
        test_mul_small();
        test_mul_carry();
        test_div();
        test_div_zero();
        test_busy_protect();
        test_done_hold();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer for 32-bit unsigned multiply and divide. It reuses the team's single-cycle ALU (add 4'b0010, sub 4'b0110) instead of a dedicated array multiplier or divider.
- Sits beside the EX stage. The pipeline pulses start, holds the stage while busy, and captures {hi,lo} on done.
- Multiply is shift-add; divide is restoring shift-subtract. Both take one ALU operation per cycle for 32 iterations.

Parameters:
- WIDTH, 32, operand width. Fixed to match the ALU; no other value is supported.
- ITER_W, 6, iteration-counter width (holds 0..32).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide; sampled with start
- a  input  32  multiplicand / dividend; sampled with start
- b  input  32  multiplier / divisor; sampled with start
- busy  output  1  high in MUL and DIV states
- done  output  1  one-cycle pulse in DONE state
- hi  output  32  multiply: product[63:32]; divide: remainder
- lo  output  32  multiply: product[31:0]; divide: quotient
- div_by_zero  output  1  set with done when op=1 and b=0; held until next accepted start

Behaviour:
- Reset
  - One clock, synchronous, active-high.
  - State goes to IDLE; counter = 0.
  - busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0.
  - rst asserted mid-operation aborts the operation with no done pulse. rst has priority over start.
- States: IDLE, MUL, DIV, DONE.
- IDLE
  - start=1 latches a, b, op, clears div_by_zero, sets counter = 0.
  - op=0: hi = 0, lo = b (multiplier), M = a → MUL.
  - op=1, b≠0: hi = 0 (remainder R), lo = a (quotient Q), D = b → DIV.
  - op=1, b=0: hi = a, lo = 32'hFFFFFFFF, div_by_zero = 1 → DONE (done appears the next cycle).
- MUL, per cycle
  - ALU in1 = hi, in2 = M, operation = add. carry = (alu_out < hi), unsigned.
  - If lo[0]=1: {hi,lo} ← {carry, alu_out, lo[31:1]}.
  - Else: {hi,lo} ← {1'b0, hi, lo[31:1]}.
- DIV, per cycle
  - Compute {ovf, Rs} = {hi, lo[31]} (33-bit shifted remainder) and Qs = {lo[30:0], 1'b0}.
  - ALU in1 = Rs, in2 = D, operation = sub.
  - If ovf=1 or Rs ≥ D (unsigned): hi ← alu_out, lo ← Qs | 1.
  - Else: hi ← Rs, lo ← Qs.
- Iteration control
  - Counter increments each MUL/DIV cycle.
  - When the counter reaches 31, that cycle's update is the last one, and the state moves to DONE.
- DONE: done = 1 for exactly one cycle → IDLE. start in DONE is ignored.
- Latency
  - start accepted on edge k; busy during cycles k+1..k+32; done in cycle k+33.
  - Divide by zero: done in cycle k+1.
- Output hold: hi, lo and div_by_zero hold their values after DONE until the next accepted start or reset.
- Busy protection: start while busy or in DONE is ignored, and operands are not re-sampled.
- ALU operation when idle is 4'b0010, which is harmless. The ALU zero output is unused.
- All arithmetic is unsigned modulo 2^32, except the 33-bit carry/overflow handling described above.

Decomposition:
- Shared package holds:
  - ALU opcode constants ALU_ADD = 4'b0010, ALU_SUB = 4'b0110 (used by the ALU control and this block).
  - Sequencer state encoding IDLE/MUL/DIV/DONE.
  - MD_OP_MUL = 0, MD_OP_DIV = 1.
- Sub-module: one instance of the existing ALU.
- Counter, state register and datapath shift logic stay in alu_muldiv_seq.

Test Plan:
- Small multiply: rst, then start op=0 a=7 b=6 at cycle 0.
  - busy during cycles 1..32; done only in cycle 33.
  - hi = 0, lo = 42.
- Multiply carry path: a = b = 32'hFFFFFFFF → hi = 32'hFFFFFFFE, lo = 32'h00000001.
- Divide:
  - op=1 a=100 b=7 → lo = 14, hi = 2, div_by_zero = 0, done at cycle 33.
  - a = 32'hFFFFFFFF b = 32'h80000001 → lo = 1, hi = 32'h7FFFFFFE (exercises ovf bit).
- Divide by zero: op=1 a=5 b=0 → done in cycle 1, hi = 5, lo = 32'hFFFFFFFF, div_by_zero = 1.
  - A subsequent mul 3*3 clears div_by_zero and gives lo = 9.
- Busy protection: during mul 7*6, pulse start op=1 a=9 b=3 at cycle 10 → ignored; result still 42, only one done pulse.
- Reset mid-op: rst at cycle 15 of a mul.
  - Next cycle: busy = 0, hi = lo = 0, no done pulse.
  - A new start 12/4 then gives lo = 3, hi = 0.
